// File: rtl/serial_sub_4bit.sv
`default_nettype none
// ============================================================================
// serial_sub_4bit : bit-serial ina - inb - borrow_in, LSB first, valid/ready.
// Optional SERIAL_SUB_OVF_EN adds the signed overflow_out port. Rev 1.0
// ============================================================================
module serial_sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_out,
`ifdef SERIAL_SUB_OVF_EN
  output logic             overflow_out,
`endif
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_ready && in_valid;
  assign w_last    = (r_cnt == C_LAST);

  assign w_a_bit   = r_a[r_cnt];
  assign w_b_bit   = r_b[r_cnt];
  assign w_d       = w_a_bit ^ w_b_bit ^ r_br;
  assign w_br_next = (~w_a_bit & w_b_bit) | (~w_a_bit & r_br) | (w_b_bit & r_br);

  // r_res accumulates privately so diff_out only changes when DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_br       <= 1'b0;
      r_cnt      <= '0;
      r_res      <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      overflow_out <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= ina;
      r_b   <= inb;
      r_br  <= borrow_in;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == S_RUN) begin
      r_br  <= w_br_next;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      if (w_last) begin
        diff_out   <= {w_d, r_res[WIDTH-1:1]};
        borrow_out <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
        overflow_out <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d != r_a[WIDTH-1]);
`endif
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_4bit.sv
`default_nettype none
// Testbench for serial_sub_4bit: directed and random operations against an
// arithmetic reference model.
module tb_serial_sub_4bit;

  localparam int WIDTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] ina = 4'd0;
  logic [3:0] inb = 4'd0;
  logic       borrow_in = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] diff_out;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       overflow_out;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  serial_sub_4bit #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ina(ina),
    .inb(inb),
    .borrow_in(borrow_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff_out(diff_out),
`ifdef SERIAL_SUB_OVF_EN
    .overflow_out(overflow_out),
`endif
    .borrow_out(borrow_out)
  );

  // Reference: {overflow, borrow, diff} from plain integer arithmetic.
  function automatic logic [5:0] model(input int a, input int b, input int bin);
    int r, sa, sb, sr;
    logic [3:0] d;
    logic bo, ov;
    r  = a - b - bin;
    d  = r[3:0];
    bo = (a < b + bin);
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    sr = sa - sb - bin;
    ov = (sr < -8) || (sr > 7);
    return {ov, bo, d};
  endfunction

  function automatic logic cur_ovf();
`ifdef SERIAL_SUB_OVF_EN
    return overflow_out;
`else
    return 1'b0;
`endif
  endfunction

  // Drives one operation; returns observations, the callers compare them.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input int hold, input logic [3:0] ma, input logic [3:0] mb,
                        output int lat, output int cyc, output logic [3:0] d,
                        output logic bo, output logic ov, output logic held_ok,
                        output logic idle_ok);
    held_ok = 1'b1;
    lat = 0;
    cyc = 0;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    ina = a;
    inb = b;
    borrow_in = bin;
    @(negedge clk); cyc++;
    in_valid = 1'b0;
    ina = ma;
    inb = mb;
    borrow_in = ~bin;
    while (!out_valid && lat < 20) begin
      @(negedge clk); lat++; cyc++;
    end
    d  = diff_out;
    bo = borrow_out;
    ov = cur_ovf();
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      ina = 4'($urandom);
      inb = 4'($urandom);
      @(negedge clk); cyc++;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && diff_out === d &&
            borrow_out === bo && cur_ovf() === ov))
        held_ok = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); cyc++;
    idle_ok = (out_valid === 1'b0 && in_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    ina = 4'd5;
    inb = 4'd3;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, diff_out, borrow_out, cur_ovf()} !== 8'b1_0_0000_0_0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b diff=%b bo=%b ov=%b want 1 0 0000 0 0",
               in_ready, out_valid, diff_out, borrow_out, cur_ovf());
    end
  endtask

  task automatic test_basic();
    logic [3:0] va[4] = '{4'd5, 4'd1, 4'd0, 4'd15};
    logic [3:0] vb[4] = '{4'd3, 4'd2, 4'd0, 4'd15};
    logic       vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat, cyc;
    logic [3:0] d;
    logic bo, ov, hok, iok;
    logic [5:0] exp;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], 0, 4'($urandom), 4'($urandom), lat, cyc, d, bo, ov, hok, iok);
      exp = model(int'(va[i]), int'(vb[i]), int'(vc[i]));
      total++;
      if ({bo, d} !== exp[4:0] || lat !== WIDTH || cyc !== WIDTH + 2 || iok !== 1'b1) begin
        bad++;
        $display("FAIL basic[%0d]: diff=%b bo=%b lat=%0d cyc=%0d idle=%b want diff=%b bo=%b lat=%0d cyc=%0d idle=1",
                 i, d, bo, lat, cyc, iok, exp[3:0], exp[4], WIDTH, WIDTH + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, cyc;
    logic [3:0] d;
    logic bo, ov, hok, iok;
    run_op(4'b0111, 4'b0010, 1'b0, 10, 4'd0, 4'd0, lat, cyc, d, bo, ov, hok, iok);
    total++;
    if (d !== 4'b0101 || bo !== 1'b0) begin
      bad++; $display("FAIL backpressure_result: diff=%b bo=%b want 0101 0", d, bo);
    end
    total++;
    if (hok !== 1'b1) begin
      bad++; $display("FAIL backpressure_hold: stable=%b want 1", hok);
    end
    total++;
    if (iok !== 1'b1 || cyc !== WIDTH + 12) begin
      bad++; $display("FAIL backpressure_release: idle=%b cyc=%0d want 1 %0d", iok, cyc, WIDTH + 12);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL backpressure_single_hs: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_operand_change();
    int lat, cyc;
    logic [3:0] d;
    logic bo, ov, hok, iok;
    run_op(4'b1010, 4'b0011, 1'b0, 0, 4'b1111, 4'b1111, lat, cyc, d, bo, ov, hok, iok);
    total++;
    if (d !== 4'b0111 || bo !== 1'b0) begin
      bad++; $display("FAIL operand_change: diff=%b bo=%b want 0111 0", d, bo);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, cyc;
    logic [3:0] d;
    logic bo, ov, hok, iok;
    logic seen;
    in_valid = 1'b1;
    ina = 4'b1001;
    inb = 4'b0100;
    borrow_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL run_flags: rdy=%b vld=%b want 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, diff_out, borrow_out, cur_ovf()} !== 8'b1_0_0000_0_0) begin
      bad++;
      $display("FAIL midrun_reset_state: rdy=%b vld=%b diff=%b bo=%b ov=%b want 1 0 0000 0 0",
               in_ready, out_valid, diff_out, borrow_out, cur_ovf());
    end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL midrun_no_valid: activity=%b want 0", seen);
    end
    run_op(4'b0110, 4'b0001, 1'b0, 0, 4'($urandom), 4'($urandom), lat, cyc, d, bo, ov, hok, iok);
    total++;
    if (d !== 4'b0101 || bo !== 1'b0 || lat !== WIDTH) begin
      bad++; $display("FAIL after_reset_op: diff=%b bo=%b lat=%0d want 0101 0 %0d", d, bo, lat, WIDTH);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_overflow();
    logic [3:0] va[3] = '{4'b1000, 4'b0111, 4'b0011};
    logic [3:0] vb[3] = '{4'b0001, 4'b1111, 4'b0001};
    logic [5:0] want[3] = '{6'b10_0111, 6'b11_1000, 6'b00_0010};
    int lat, cyc;
    logic [3:0] d;
    logic bo, ov, hok, iok;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 1'b0, 1, 4'd0, 4'd0, lat, cyc, d, bo, ov, hok, iok);
      total++;
      if ({ov, bo, d} !== want[i] || hok !== 1'b1) begin
        bad++;
        $display("FAIL overflow[%0d]: ov=%b bo=%b diff=%b held=%b want ov=%b bo=%b diff=%b held=1",
                 i, ov, bo, d, hok, want[i][5], want[i][4], want[i][3:0]);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    int lat, cyc;
    logic [3:0] a, b, d;
    logic c, bo, ov, hok, iok;
    logic [5:0] exp;
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      c = 1'($urandom);
      run_op(a, b, c, 0, 4'($urandom), 4'($urandom), lat, cyc, d, bo, ov, hok, iok);
      exp = model(int'(a), int'(b), int'(c));
      total++;
      if ({bo, d} !== exp[4:0] || cyc !== WIDTH + 2 || iok !== 1'b1) begin
        bad++;
        $display("FAIL back_to_back[%0d]: %0d-%0d-%0d diff=%b bo=%b cyc=%0d want diff=%b bo=%b cyc=%0d",
                 i, a, b, c, d, bo, cyc, exp[3:0], exp[4], WIDTH + 2);
      end
    end
  endtask

  task automatic test_random();
    int lat, cyc, hold;
    logic [3:0] a, b, d;
    logic c, bo, ov, hok, iok;
    logic [5:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      c = 1'($urandom);
      hold = $urandom_range(0, 3);
      run_op(a, b, c, hold, 4'($urandom), 4'($urandom), lat, cyc, d, bo, ov, hok, iok);
      exp = model(int'(a), int'(b), int'(c));
`ifndef SERIAL_SUB_OVF_EN
      exp[5] = 1'b0;
`endif
      total++;
      if ({ov, bo, d} !== exp || lat !== WIDTH || hok !== 1'b1 || iok !== 1'b1) begin
        bad++;
        $display("FAIL random[%0d]: %0d-%0d-%0d got ov=%b bo=%b diff=%b lat=%0d held=%b idle=%b want ov=%b bo=%b diff=%b lat=%0d",
                 i, a, b, c, ov, bo, d, lat, hok, iok, exp[5], exp[4], exp[3:0], WIDTH);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_operand_change();
    test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
    test_overflow();
`endif
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
